// File: rtl/multi_clock_divider.sv
// Multi-channel runtime-programmable clock divider: square-wave enable plus period strobe per channel.
// Optional divisor readback port enabled by defining MULTI_CLOCK_DIVIDER_RDBACK_EN.
module multi_clock_divider #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned DEFAULT_DIV = 50000
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             sync_restart,
`ifdef MULTI_CLOCK_DIVIDER_RDBACK_EN
  input  logic [CH_W-1:0]  rd_ch,
  output logic [DIV_W-1:0] rd_div,
`endif
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   cfg_pending
);

  logic [DIV_W-1:0] cnt_q   [NCH];
  logic [DIV_W-1:0] cnt_d   [NCH];
  logic [DIV_W-1:0] act_q   [NCH];
  logic [DIV_W-1:0] act_d   [NCH];
  logic [DIV_W-1:0] pval_q  [NCH];
  logic [DIV_W-1:0] pval_d  [NCH];
  logic [DIV_W-1:0] applied [NCH];
  logic [NCH-1:0]   pend_d;
  logic [NCH-1:0]   clk_d;
  logic [NCH-1:0]   tick_d;
  logic [NCH-1:0]   wr_hit;
  logic [NCH-1:0]   boundary;

  // Next-state per channel; a disabled channel treats every cycle as a period boundary
  always_comb begin
    pend_d   = cfg_pending;
    clk_d    = '0;
    tick_d   = '0;
    wr_hit   = '0;
    boundary = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]    = cnt_q[i] + DIV_W'(1);
      act_d[i]    = act_q[i];
      pval_d[i]   = pval_q[i];
      wr_hit[i]   = cfg_we && (cfg_ch == CH_W'(i));
      applied[i]  = wr_hit[i] ? cfg_div : (cfg_pending[i] ? pval_q[i] : act_q[i]);
      boundary[i] = sync_restart || (act_q[i] < DIV_W'(2)) ||
                    (cnt_q[i] == act_q[i] - DIV_W'(1));
      if (boundary[i]) begin
        cnt_d[i]  = '0;
        act_d[i]  = applied[i];
        pend_d[i] = 1'b0;
      end else if (wr_hit[i]) begin
        pend_d[i] = 1'b1;
        pval_d[i] = cfg_div;
      end
      // Outputs derived from the next count/divisor so they stay aligned with cnt
      if (act_d[i] >= DIV_W'(2)) begin
        clk_d[i]  = (cnt_d[i] >= (act_d[i] >> 1));
        tick_d[i] = (cnt_d[i] == act_d[i] - DIV_W'(1));
      end
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        act_q[i]  <= DIV_W'(DEFAULT_DIV);
        pval_q[i] <= '0;
      end
      clk_out     <= '0;
      tick        <= '0;
      cfg_pending <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        act_q[i]  <= act_d[i];
        pval_q[i] <= pval_d[i];
      end
      clk_out     <= clk_d;
      tick        <= tick_d;
      cfg_pending <= pend_d;
    end
  end

`ifdef MULTI_CLOCK_DIVIDER_RDBACK_EN
  logic [DIV_W-1:0] rd_sel;

  // Out-of-range channel selects read back as zero
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch == CH_W'(i)) rd_sel = act_q[i];
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (!rst) rd_div <= '0;
    else      rd_div <= rd_sel;
  end
`endif

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider (DEFAULT_DIV=4); a 3-channel instance covers out-of-range writes.
module tb_multi_clock_divider;

  logic        clk_50mhz;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic        sync_restart;
  logic [3:0]  clk_out, tick, cfg_pending;
  logic [2:0]  clk_out3, tick3, cfg_pending3;
`ifdef MULTI_CLOCK_DIVIDER_RDBACK_EN
  logic [1:0]  rd_ch;
  logic [31:0] rd_div, rd_div3;
`endif

  int vectors;
  int miscompares;
  int div_m [4];
  int base  [4];

  multi_clock_divider #(.NCH(4), .DIV_W(32), .CH_W(2), .DEFAULT_DIV(4)) dut (
    .clk_50mhz(clk_50mhz), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .sync_restart(sync_restart),
`ifdef MULTI_CLOCK_DIVIDER_RDBACK_EN
    .rd_ch(rd_ch), .rd_div(rd_div),
`endif
    .clk_out(clk_out), .tick(tick), .cfg_pending(cfg_pending)
  );

  multi_clock_divider #(.NCH(3), .DIV_W(32), .CH_W(2), .DEFAULT_DIV(4)) dut3 (
    .clk_50mhz(clk_50mhz), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .sync_restart(sync_restart),
`ifdef MULTI_CLOCK_DIVIDER_RDBACK_EN
    .rd_ch(rd_ch), .rd_div(rd_div3),
`endif
    .clk_out(clk_out3), .tick(tick3), .cfg_pending(cfg_pending3)
  );

  initial clk_50mhz = 1'b0;
  always #5 clk_50mhz = ~clk_50mhz;

  // Expected waveforms: channel i has divisor div_m[i] with cnt=0 at cycle base[i]
  function automatic logic [3:0] exp_clk(input int k);
    logic [3:0] r;
    int c;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (div_m[i] >= 2) begin
        c = (k - base[i]) % div_m[i];
        r[i] = (c >= div_m[i] / 2);
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_tick(input int k);
    logic [3:0] r;
    int c;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (div_m[i] >= 2) begin
        c = (k - base[i]) % div_m[i];
        r[i] = (c == div_m[i] - 1);
      end
    end
    return r;
  endfunction

  task automatic cyc();
    @(negedge clk_50mhz);
  endtask

  task automatic restart_all();
    sync_restart = 1'b1;
    cyc();
    sync_restart = 1'b0;
    for (int c = 0; c < 4; c++) base[c] = 0;
  endtask

  task automatic test_reset();
    cyc(); cyc(); cyc();
    vectors++;
    if ({clk_out, tick, cfg_pending} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_hold got %h want 000", {clk_out, tick, cfg_pending});
    end
    for (int c = 0; c < 4; c++) begin div_m[c] = 4; base[c] = 0; end
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (clk_out !== exp_clk(k)) begin
        miscompares++; $display("FAIL reset_clk k=%0d got %b want %b", k, clk_out, exp_clk(k));
      end
      vectors++;
      if (tick !== exp_tick(k)) begin
        miscompares++; $display("FAIL reset_tick k=%0d got %b want %b", k, tick, exp_tick(k));
      end
      cyc();
    end
  endtask

  task automatic test_div_write();
    logic [3:0] pe;
    restart_all();
    for (int k = 0; k < 25; k++) begin
      if (k == 4) begin div_m[1] = 5; base[1] = 4; end
      pe = (k >= 2 && k <= 3) ? 4'b0010 : 4'b0000;
      vectors++;
      if (clk_out !== exp_clk(k)) begin
        miscompares++; $display("FAIL wr5_clk k=%0d got %b want %b", k, clk_out, exp_clk(k));
      end
      vectors++;
      if (tick !== exp_tick(k)) begin
        miscompares++; $display("FAIL wr5_tick k=%0d got %b want %b", k, tick, exp_tick(k));
      end
      vectors++;
      if (cfg_pending !== pe) begin
        miscompares++; $display("FAIL wr5_pend k=%0d got %b want %b", k, cfg_pending, pe);
      end
      cfg_we = (k == 1);
      cfg_ch = 2'd1;
      cfg_div = 32'd5;
      cyc();
    end
  endtask

  task automatic test_last_write_wins();
    logic [3:0] pe;
    restart_all();
    for (int k = 0; k < 41; k++) begin
      if (k == 4)  begin div_m[2] = 10; base[2] = 4; end
      if (k == 24) begin div_m[2] = 12; base[2] = 24; end
      pe = ((k >= 2 && k <= 3) || (k >= 16 && k <= 23)) ? 4'b0100 : 4'b0000;
      vectors++;
      if (clk_out !== exp_clk(k)) begin
        miscompares++; $display("FAIL lww_clk k=%0d got %b want %b", k, clk_out, exp_clk(k));
      end
      vectors++;
      if (tick !== exp_tick(k)) begin
        miscompares++; $display("FAIL lww_tick k=%0d got %b want %b", k, tick, exp_tick(k));
      end
      vectors++;
      if (cfg_pending !== pe) begin
        miscompares++; $display("FAIL lww_pend k=%0d got %b want %b", k, cfg_pending, pe);
      end
      cfg_we = (k == 1 || k == 2 || k == 15 || k == 23);
      cfg_ch = 2'd2;
      cfg_div = (k == 1) ? 32'd6 : (k == 2) ? 32'd10 : (k == 15) ? 32'd7 : 32'd12;
      cyc();
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_disable();
    logic [3:0] pe;
    restart_all();
    for (int k = 0; k < 21; k++) begin
      if (k == 4)  div_m[3] = 0;
      if (k == 11) begin div_m[3] = 2; base[3] = 11; end
      pe = (k >= 2 && k <= 3) ? 4'b1000 : 4'b0000;
      vectors++;
      if (clk_out !== exp_clk(k)) begin
        miscompares++; $display("FAIL dis_clk k=%0d got %b want %b", k, clk_out, exp_clk(k));
      end
      vectors++;
      if (tick !== exp_tick(k)) begin
        miscompares++; $display("FAIL dis_tick k=%0d got %b want %b", k, tick, exp_tick(k));
      end
      vectors++;
      if (cfg_pending !== pe) begin
        miscompares++; $display("FAIL dis_pend k=%0d got %b want %b", k, cfg_pending, pe);
      end
      cfg_we = (k == 1 || k == 10);
      cfg_ch = 2'd3;
      cfg_div = (k == 1) ? 32'd0 : 32'd2;
      cyc();
    end
  endtask

  task automatic test_sync_restart();
    cfg_we = 1'b1;
    cfg_ch = 2'd0; cfg_div = 32'd4; cyc();
    cfg_ch = 2'd1; cfg_div = 32'd6; cyc();
    cfg_ch = 2'd2; cfg_div = 32'd8; cyc();
    cfg_ch = 2'd3; cfg_div = 32'd10; sync_restart = 1'b1; cyc();
    cfg_we = 1'b0; sync_restart = 1'b0;
    div_m[0] = 4; div_m[1] = 6; div_m[2] = 8; div_m[3] = 10;
    for (int c = 0; c < 4; c++) base[c] = 0;
    for (int k = 0; k < 122; k++) begin
      vectors++;
      if (clk_out !== exp_clk(k)) begin
        miscompares++; $display("FAIL sync_clk k=%0d got %b want %b", k, clk_out, exp_clk(k));
      end
      vectors++;
      if (tick !== exp_tick(k)) begin
        miscompares++; $display("FAIL sync_tick k=%0d got %b want %b", k, tick, exp_tick(k));
      end
      vectors++;
      if (cfg_pending !== 4'b0000) begin
        miscompares++; $display("FAIL sync_pend k=%0d got %b want 0000", k, cfg_pending);
      end
      if (k == 119) begin
        vectors++;
        if (tick !== 4'b1111) begin
          miscompares++; $display("FAIL sync_lcm got %b want 1111", tick);
        end
      end
      cyc();
    end
    sync_restart = 1'b1;
    for (int h = 0; h < 3; h++) begin
      cyc();
      vectors++;
      if ({clk_out, tick} !== 8'h00) begin
        miscompares++; $display("FAIL sync_hold h=%0d got %h want 00", h, {clk_out, tick});
      end
    end
    sync_restart = 1'b0;
  endtask

  task automatic test_reset_pending();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd7;
    cyc();
    cfg_we = 1'b0;
    vectors++;
    if (cfg_pending !== 4'b0010) begin
      miscompares++; $display("FAIL rstp_pend_pre got %b want 0010", cfg_pending);
    end
    rst = 1'b0;
    cyc();
    vectors++;
    if ({clk_out, tick, cfg_pending} !== 12'h000) begin
      miscompares++; $display("FAIL rstp_zero got %h want 000", {clk_out, tick, cfg_pending});
    end
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin div_m[c] = 4; base[c] = 0; end
    for (int k = 0; k < 13; k++) begin
      vectors++;
      if (clk_out !== exp_clk(k)) begin
        miscompares++; $display("FAIL rstp_clk k=%0d got %b want %b", k, clk_out, exp_clk(k));
      end
      vectors++;
      if ({tick, cfg_pending} !== {exp_tick(k), 4'b0000}) begin
        miscompares++; $display("FAIL rstp_tick k=%0d got %b want %b", k, {tick, cfg_pending}, {exp_tick(k), 4'b0000});
      end
`ifdef MULTI_CLOCK_DIVIDER_RDBACK_EN
      if (k >= 1) begin
        vectors++;
        if (rd_div !== 32'd4) begin
          miscompares++; $display("FAIL rstp_rdback k=%0d got %0d want 4", k, rd_div);
        end
      end
      rd_ch = 2'(k % 4);
`endif
      cyc();
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] e;
    logic [3:0] t;
    restart_all();
    for (int k = 0; k < 11; k++) begin
      e = exp_clk(k);
      t = exp_tick(k);
      if (k == 2) begin
        vectors++;
        if (cfg_pending !== 4'b1000) begin
          miscompares++; $display("FAIL oor_main_pend got %b want 1000", cfg_pending);
        end
      end
      vectors++;
      if (cfg_pending3 !== 3'b000) begin
        miscompares++; $display("FAIL oor_pend k=%0d got %b want 000", k, cfg_pending3);
      end
      vectors++;
      if ({clk_out3, tick3} !== {e[2:0], t[2:0]}) begin
        miscompares++; $display("FAIL oor_wave k=%0d got %b want %b", k, {clk_out3, tick3}, {e[2:0], t[2:0]});
      end
      cfg_we = (k == 1);
      cfg_ch = 2'd3;
      cfg_div = 32'd9;
      cyc();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_div = '0;
    sync_restart = 1'b0;
`ifdef MULTI_CLOCK_DIVIDER_RDBACK_EN
    rd_ch = '0;
`endif
    test_reset();
    test_div_write();
    test_last_write_wins();
    test_disable();
    test_sync_restart();
    test_reset_pending();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
